// File: rtl/temp_bcd_conv_pkg.sv
// Shared widths, BCD digit type and FSM state encoding for the ADT7420-to-BCD converter.
package temp_pkg;

  localparam int TEMP_W       = 13;
  localparam int FRAC_BITS    = 4;
  localparam int INT_BITS     = 9;
  localparam int SHIFT_CYCLES = 9;
  localparam int HUND_BITS    = 7;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sixteenths to hundredths, truncated: f * 100 / 16 == (f * 25) >> 2.
  function automatic logic [HUND_BITS-1:0] frac_hund(input logic [FRAC_BITS-1:0] f);
    return HUND_BITS'(({5'd0, f} * 9'd25) >> 2);
  endfunction

endpackage

// File: rtl/temp_bcd_conv_if.sv
// Sample-in / BCD-result-out bundle of the temperature converter.
interface temp_bcd_conv_if;
  import temp_pkg::*;

  logic [TEMP_W-1:0] temp_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic              sign_o;
  bcd_t              hund_o;
  bcd_t              tens_o;
  bcd_t              ones_o;
  bcd_t              frac_tens_o;
  bcd_t              frac_ones_o;

  modport master (
    output temp_i, in_valid_i,
    input  in_ready_o, out_valid_o, sign_o, hund_o, tens_o, ones_o, frac_tens_o, frac_ones_o
  );

  modport slave (
    input  temp_i, in_valid_i,
    output in_ready_o, out_valid_o, sign_o, hund_o, tens_o, ones_o, frac_tens_o, frac_ones_o
  );

endinterface

// File: rtl/temp_bcd_conv_add3.sv
// Double-dabble per-digit correction: digits of 5 or more get 3 added before the shift.
module bcd_add3
  import temp_pkg::*;
(
  input  bcd_t din,
  output bcd_t dout
);

  // Add-3 correction of one BCD digit
  always_comb begin
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/temp_bcd_conv.sv
// ADT7420 13-bit temperature to sign + 3 integer BCD digits + 2 hundredths BCD digits.
// Hundredths conversion is present only when TEMP_BCD_FRAC_EN is defined.
module temp_bcd_conv
  import temp_pkg::*;
(
  input logic            clk_i,
  input logic            rstn_i,
  temp_bcd_conv_if.slave bus
);

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                sign_r;
  logic                sign_out_r;
  logic [TEMP_W-1:0]   temp_r;
  logic [INT_BITS-1:0] bin_r;
  logic [INT_BITS-1:0] mag_int_s;
  logic [11:0]         bcd_r;
  logic [11:0]         bcd_a_s;
  logic [11:0]         bcd_nxt_s;
  bcd_t                hund_r;
  bcd_t                tens_r;
  bcd_t                ones_r;
  logic                last_iter_s;

  bcd_add3 u_add3_ones (.din(bcd_r[3:0]),  .dout(bcd_a_s[3:0]));
  bcd_add3 u_add3_tens (.din(bcd_r[7:4]),  .dout(bcd_a_s[7:4]));
  bcd_add3 u_add3_hund (.din(bcd_r[11:8]), .dout(bcd_a_s[11:8]));

  assign last_iter_s = (cnt_r == 4'(SHIFT_CYCLES - 1));
  assign bcd_nxt_s   = 12'({bcd_a_s, bin_r[INT_BITS-1]});

`ifdef TEMP_BCD_FRAC_EN
  logic [TEMP_W-1:0]    mag_s;
  logic [HUND_BITS-1:0] fbin_r;
  logic [7:0]           fbcd_r;
  logic [7:0]           fbcd_a_s;
  logic [7:0]           fbcd_nxt_s;
  bcd_t                 ftens_r;
  bcd_t                 fones_r;

  // 0x1000 negates to itself, which reads correctly as unsigned 4096.
  assign mag_s      = temp_r[TEMP_W-1] ? (13'd0 - temp_r) : temp_r;
  assign mag_int_s  = mag_s[TEMP_W-1:FRAC_BITS];
  assign fbcd_nxt_s = 8'({fbcd_a_s, fbin_r[HUND_BITS-1]});

  bcd_add3 u_add3_fones (.din(fbcd_r[3:0]), .dout(fbcd_a_s[3:0]));
  bcd_add3 u_add3_ftens (.din(fbcd_r[7:4]), .dout(fbcd_a_s[7:4]));

  // Hundredths double-dabble: 7 iterations, then held until the result is latched
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fbin_r  <= 7'd0;
      fbcd_r  <= 8'd0;
      ftens_r <= 4'd0;
      fones_r <= 4'd0;
    end else begin
      case (state_r)
        LOAD: begin
          fbin_r <= frac_hund(mag_s[FRAC_BITS-1:0]);
          fbcd_r <= 8'd0;
        end
        SHIFT: begin
          if (cnt_r < 4'(HUND_BITS)) begin
            fbin_r <= {fbin_r[HUND_BITS-2:0], 1'b0};
            fbcd_r <= fbcd_nxt_s;
          end
          if (last_iter_s) begin
            ftens_r <= fbcd_r[7:4];
            fones_r <= fbcd_r[3:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.frac_tens_o = ftens_r;
  assign bus.frac_ones_o = fones_r;
`else
  assign mag_int_s = INT_BITS'((temp_r[TEMP_W-1] ? (13'd0 - temp_r) : temp_r) >> FRAC_BITS);

  assign bus.frac_tens_o = 4'd0;
  assign bus.frac_ones_o = 4'd0;
`endif

  // Control FSM, integer double-dabble and result registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sign_r      <= 1'b0;
      sign_out_r  <= 1'b0;
      temp_r      <= 13'd0;
      bin_r       <= 9'd0;
      bcd_r       <= 12'd0;
      hund_r      <= 4'd0;
      tens_r      <= 4'd0;
      ones_r      <= 4'd0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.in_valid_i) begin
            temp_r     <= bus.temp_i;
            in_ready_r <= 1'b0;
            state_r    <= LOAD;
          end
        end
        LOAD: begin
          bin_r   <= mag_int_s;
          bcd_r   <= 12'd0;
          sign_r  <= temp_r[TEMP_W-1];
          cnt_r   <= 4'd0;
          state_r <= SHIFT;
        end
        SHIFT: begin
          bin_r <= {bin_r[INT_BITS-2:0], 1'b0};
          bcd_r <= bcd_nxt_s;
          if (last_iter_s) begin
            hund_r      <= bcd_nxt_s[11:8];
            tens_r      <= bcd_nxt_s[7:4];
            ones_r      <= bcd_nxt_s[3:0];
            sign_out_r  <= sign_r;
            out_valid_r <= 1'b1;
            cnt_r       <= 4'd0;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        DONE: begin
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_r;
  assign bus.out_valid_o = out_valid_r;
  assign bus.sign_o      = sign_out_r;
  assign bus.hund_o      = hund_r;
  assign bus.tens_o      = tens_r;
  assign bus.ones_o      = ones_r;

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Self-checking bench for temp_bcd_conv: directed table, random samples against an
// arithmetic reference model, back-to-back accepts and reset abort.
module tb_temp_bcd_conv;

`ifdef TEMP_BCD_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  typedef struct packed {
    logic       s;
    logic [3:0] h;
    logic [3:0] tn;
    logic [3:0] o;
    logic [3:0] ft;
    logic [3:0] fo;
  } res_t;

  typedef struct packed {
    logic [12:0] t;
    res_t        r;
  } vec_t;

  logic clk_i;
  logic rstn_i;
  int   checks;
  int   failures;

  temp_bcd_conv_if bus_if ();

  temp_bcd_conv dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the reading in 1/16 degC.
  function automatic res_t model(input logic [12:0] t);
    res_t r;
    int   v;
    int   mag;
    int   ip;
    int   fp;
    v    = $signed(t);
    mag  = (v < 0) ? -v : v;
    ip   = mag / 16;
    fp   = ((mag % 16) * 100) / 16;
    r.s  = (v < 0);
    r.h  = 4'(ip / 100);
    r.tn = 4'((ip / 10) % 10);
    r.o  = 4'(ip % 10);
    r.ft = FRAC_ON ? 4'(fp / 10) : 4'd0;
    r.fo = FRAC_ON ? 4'(fp % 10) : 4'd0;
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.s  = bus_if.sign_o;
    r.h  = bus_if.hund_o;
    r.tn = bus_if.tens_o;
    r.o  = bus_if.ones_o;
    r.ft = bus_if.frac_tens_o;
    r.fo = bus_if.frac_ones_o;
    return r;
  endfunction

  task automatic run_conv(input logic [12:0] t, input res_t exp, input string tag);
    int k;
    @(negedge clk_i);
    for (int i = 0; i < 30 && !bus_if.in_ready_o; i++) @(negedge clk_i);
    chk({tag, "_ready"}, 32'(bus_if.in_ready_o), 32'd1);
    bus_if.temp_i     = t;
    bus_if.in_valid_i = 1'b1;
    @(negedge clk_i);
    bus_if.in_valid_i = 1'b0;
    bus_if.temp_i     = 13'($urandom);
    chk({tag, "_busy"}, 32'(bus_if.in_ready_o), 32'd0);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!bus_if.out_valid_o && k < 20);
    chk({tag, "_latency"}, 32'(k), 32'd10);
    chk({tag, "_result"}, 32'(dut_res()), 32'(exp));
    @(negedge clk_i);
    chk({tag, "_pulse"}, 32'(bus_if.out_valid_o), 32'd0);
    chk({tag, "_hold"}, 32'(dut_res()), 32'(exp));
  endtask

  vec_t tbl[9];
  res_t q[$];

  initial begin
    res_t e;
    res_t zero;
    logic [12:0] t;
    int   last;
    int   accepts;
    int   pulses;

    checks   = 0;
    failures = 0;
    zero     = '0;

    tbl[0] = '{t: 13'h0190, r: '{s: 1'b0, h: 4'd0, tn: 4'd2, o: 4'd5, ft: 4'd0, fo: 4'd0}};
    tbl[1] = '{t: 13'h1FFF, r: '{s: 1'b1, h: 4'd0, tn: 4'd0, o: 4'd0, ft: 4'd0, fo: 4'd6}};
    tbl[2] = '{t: 13'h1C90, r: '{s: 1'b1, h: 4'd0, tn: 4'd5, o: 4'd5, ft: 4'd0, fo: 4'd0}};
    tbl[3] = '{t: 13'h1000, r: '{s: 1'b1, h: 4'd2, tn: 4'd5, o: 4'd6, ft: 4'd0, fo: 4'd0}};
    tbl[4] = '{t: 13'h0FFF, r: '{s: 1'b0, h: 4'd2, tn: 4'd5, o: 4'd5, ft: 4'd9, fo: 4'd3}};
    tbl[5] = '{t: 13'h0000, r: '{s: 1'b0, h: 4'd0, tn: 4'd0, o: 4'd0, ft: 4'd0, fo: 4'd0}};
    tbl[6] = '{t: 13'h0008, r: '{s: 1'b0, h: 4'd0, tn: 4'd0, o: 4'd0, ft: 4'd5, fo: 4'd0}};
    tbl[7] = '{t: 13'h1FF8, r: '{s: 1'b1, h: 4'd0, tn: 4'd0, o: 4'd0, ft: 4'd5, fo: 4'd0}};
    tbl[8] = '{t: 13'h07D0, r: '{s: 1'b0, h: 4'd1, tn: 4'd2, o: 4'd5, ft: 4'd0, fo: 4'd0}};

    rstn_i            = 1'b0;
    bus_if.in_valid_i = 1'b0;
    bus_if.temp_i     = 13'd0;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    chk("rst_ready", 32'(bus_if.in_ready_o), 32'd1);
    chk("rst_valid", 32'(bus_if.out_valid_o), 32'd0);
    chk("rst_outputs", 32'(dut_res()), 32'(zero));

    foreach (tbl[i]) begin
      e = tbl[i].r;
      if (!FRAC_ON) begin
        e.ft = 4'd0;
        e.fo = 4'd0;
      end
      run_conv(tbl[i].t, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      t = 13'($urandom_range(0, 8191));
      run_conv(t, model(t), $sformatf("rnd%0d", i));
    end

    // in_valid_i held high with a fresh value every cycle
    last    = -1;
    accepts = 0;
    for (int c = 0; c < 62; c++) begin
      @(negedge clk_i);
      if (bus_if.out_valid_o) begin
        chk("b2b_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_result", 32'(dut_res()), 32'(e));
        end
      end
      t                 = 13'($urandom);
      bus_if.temp_i     = t;
      bus_if.in_valid_i = 1'b1;
      if (bus_if.in_ready_o) begin
        if (last >= 0) chk("b2b_interval", 32'(c - last), 32'd12);
        last = c;
        accepts++;
        q.push_back(model(t));
      end
    end
    bus_if.in_valid_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (bus_if.out_valid_o) begin
        chk("b2b_drain_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_drain_result", 32'(dut_res()), 32'(e));
        end
      end
    end
    chk("b2b_accepts", 32'(accepts), 32'd6);
    chk("b2b_queue_empty", 32'(q.size()), 32'd0);

    // Reset while in SHIFT iteration 5 aborts the sample
    run_conv(13'h0FFF, model(13'h0FFF), "pre_abort");
    bus_if.temp_i     = 13'h07D0;
    bus_if.in_valid_i = 1'b1;
    @(negedge clk_i);
    bus_if.in_valid_i = 1'b0;
    repeat (6) @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    chk("abort_ready", 32'(bus_if.in_ready_o), 32'd1);
    chk("abort_valid", 32'(bus_if.out_valid_o), 32'd0);
    chk("abort_outputs", 32'(dut_res()), 32'(zero));
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk_i);
      if (bus_if.out_valid_o) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    run_conv(13'h1C90, model(13'h1C90), "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
